// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : State/forwarding encodings and the XZR constant for the controller.
// Rev    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] XZR = 5'd31;

    // A write to XZR is discarded, so it can never be a forwarding source.
    function automatic logic reg_match(input logic we, input logic [4:0] rd,
                                       input logic [4:0] rs);
        return we && (rd != XZR) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/forward_select.sv
`default_nettype none
// ============================================================================
// Module : forward_select
// Brief  : Combinational ALU operand source select for one EX source register.
// Rev    : 1.0  initial release
// ============================================================================
module forward_select
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_reg_write,
    output logic [1:0] o_fwd
);

    // MEM holds the younger result, so it takes priority over WB.
    always_comb begin
        o_fwd = FWD_RF;
        if (reg_match(i_mem_reg_write, i_mem_rd, i_src)) begin
            o_fwd = FWD_MEM;
        end else if (reg_match(i_wb_reg_write, i_wb_rd, i_src)) begin
            o_fwd = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module : pipeline_controller
// Brief  : Hazard/stall/flush FSM with operand forwarding for a 5-stage pipe.
//          Optional performance counters enabled by macro PIPE_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module pipeline_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int STARTUP_CYCLES = 2,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             register_reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic [4:0]       ex_rn,
    input  logic [4:0]       ex_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             mem_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned        SU_W        = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [SU_W-1:0]    c_init_last = SU_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_next;
    logic [SU_W-1:0]  r_init_cnt;
    logic [SU_W-1:0]  w_init_cnt_next;
    logic             w_active;
    logic             w_load_use;
    logic             w_branch;
    logic             w_unused_ex_reg_write;

    assign w_unused_ex_reg_write = ex_reg_write;

    always_ff @(posedge clk) begin
        if (register_reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= w_init_cnt_next;
        end
    end

    assign w_active   = (r_state == ST_RUN) || (r_state == ST_STALL);
    assign w_load_use = w_active && ex_mem_read && (ex_rd != XZR) &&
                        ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    assign w_branch   = w_active && mem_branch_taken;

    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        id_ex_bubble    = 1'b0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;
        flush_ex_mem    = 1'b0;
        case (r_state)
            ST_INIT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
                if (r_init_cnt == c_init_last) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_init_cnt_next = r_init_cnt + SU_W'(1);
                end
            end
            ST_RUN, ST_STALL: begin
                // A taken branch squashes the dependent instruction, so it beats the stall.
                if (w_branch) begin
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    flush_ex_mem = 1'b1;
                    w_state_next = ST_FLUSH;
                end else if (w_load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    w_state_next = ST_STALL;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
        if (register_reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end
    end

    assign ctrl_state = register_reset ? ST_INIT : r_state;

    forward_select u_fwd_a (
        .i_src           (ex_rn),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_fwd           (fwd_a)
    );

    forward_select u_fwd_b (
        .i_src           (ex_rm),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_fwd           (fwd_b)
    );

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (register_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (id_ex_bubble && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            // Startup flushes are housekeeping, not branch penalties.
            if (flush_ex_mem && (r_state != ST_INIT) && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
`default_nettype wire
